// File: rtl/data_sram_arbiter.sv
// data_sram_arbiter
//   Shares one single-ported synchronous data SRAM between two requesters:
//   port 0 (CPU load/store path) and port 1 (debug/DMA loader). At most one
//   access is accepted per cycle. The completion strobe and read data are
//   returned to the issuing port one cycle later. A port that accepts with
//   lock=1 keeps the SRAM until it releases the lock.
//
//   Build option: define DSRAM_ARB_RR_EN for round-robin tie breaking.
//   When it is undefined, port 0 always wins a tie and port 1 can starve.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   pN_req/wr/wstrb/addr/wdata   access request from port N (held until accepted)
//   pN_lock                      keep ownership after the current access
//   pN_addr_ok                   request accepted this cycle
//   pN_data_ok, pN_rdata         completion strobe and read data, one cycle later
//   data_sram_*                  SRAM interface (rdata valid one cycle after en)
module data_sram_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [3:0]        p0_wstrb,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic              p0_lock,
  output logic              p0_addr_ok,
  output logic              p0_data_ok,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [3:0]        p1_wstrb,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic              p1_lock,
  output logic              p1_addr_ok,
  output logic              p1_data_ok,
  output logic [31:0]       p1_rdata,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic [31:0]       data_sram_rdata
);

  logic r_resp_valid;
  logic r_resp_port;
  logic r_lock_valid;
  logic r_lock_port;

  logic w_gnt0;
  logic w_gnt1;
  logic w_acc;
  logic w_sel_lock;
  logic w_own_req;
  logic w_own_lock;

`ifdef DSRAM_ARB_RR_EN
  logic r_prio;  // port that wins the next tie
`endif

  // Grant: a lock owner excludes the other port entirely.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_lock_valid) begin
      w_gnt0 = p0_req && !r_lock_port;
      w_gnt1 = p1_req &&  r_lock_port;
    end else if (p0_req && p1_req) begin
`ifdef DSRAM_ARB_RR_EN
      w_gnt0 = !r_prio;
      w_gnt1 =  r_prio;
`else
      w_gnt0 = 1'b1;
`endif
    end else begin
      w_gnt0 = p0_req;
      w_gnt1 = p1_req;
    end
  end

  assign w_acc      = w_gnt0 || w_gnt1;
  assign p0_addr_ok = w_gnt0;
  assign p1_addr_ok = w_gnt1;

  // SRAM mux; port 0 values pass through when idle.
  always_comb begin
    data_sram_en    = w_acc;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = p0_addr;
    data_sram_wdata = p0_wdata;
    if (w_gnt1) begin
      data_sram_addr  = p1_addr;
      data_sram_wdata = p1_wdata;
      data_sram_wen   = p1_wr ? p1_wstrb : 4'b0000;
    end else if (w_gnt0) begin
      data_sram_wen   = p0_wr ? p0_wstrb : 4'b0000;
    end
  end

  assign w_sel_lock = w_gnt1 ? p1_lock : p0_lock;
  assign w_own_req  = r_lock_port ? p1_req  : p0_req;
  assign w_own_lock = r_lock_port ? p1_lock : p0_lock;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_port  <= 1'b0;
      r_lock_valid <= 1'b0;
      r_lock_port  <= 1'b0;
    end else begin
      r_resp_valid <= w_acc;
      if (w_acc) begin
        r_resp_port <= w_gnt1;
      end
      // Only the owner can be accepted while locked, so an accept always
      // rewrites the lock from the accepting port's lock input.
      if (w_acc) begin
        r_lock_valid <= w_sel_lock;
        r_lock_port  <= w_gnt1;
      end else if (r_lock_valid && !w_own_req && !w_own_lock) begin
        r_lock_valid <= 1'b0;
      end
    end
  end

`ifdef DSRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prio <= 1'b0;
    end else if (w_acc && p0_req && p1_req) begin
      r_prio <= !w_gnt1;
    end
  end
`endif

  assign p0_data_ok = r_resp_valid && !r_resp_port;
  assign p1_data_ok = r_resp_valid &&  r_resp_port;
  assign p0_rdata   = p0_data_ok ? data_sram_rdata : 32'h0;
  assign p1_rdata   = p1_data_ok ? data_sram_rdata : 32'h0;

endmodule

// File: doc/data_sram_arbiter.md
# data_sram_arbiter

Shares the single-ported synchronous data SRAM between two requesters:
- **port 0**: the CPU load/store path feeding the memory stage;
- **port 1**: a secondary master (debug/DMA loader).

Accepts at most one access per cycle and drives the SRAM. It tracks the one-cycle read latency and returns read data and a completion strobe to the port that issued the access. A lock input lets one port hold the SRAM across back-to-back accesses for read-modify-write sequences.

## Interface
- `ADDR_W`, 32: byte address width, passed through to the SRAM.
- `clk` input 1: single clock; all state updates on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` input 1: access request, held until accepted.
- `p0_wr`, `p1_wr` input 1: 1 = write, 0 = read.
- `p0_wstrb`, `p1_wstrb` input 4: byte write enables; ignored for reads.
- `p0_addr`, `p1_addr` input ADDR_W: byte address.
- `p0_wdata`, `p1_wdata` input 32: write data.
- `p0_lock`, `p1_lock` input 1: keep ownership after the current access.
- `p0_addr_ok`, `p1_addr_ok` output 1: request accepted this cycle.
- `p0_data_ok`, `p1_data_ok` output 1: access completed; read data valid.
- `p0_rdata`, `p1_rdata` output 32: read data, valid only while the matching `data_ok` is high.
- `data_sram_en` output 1: SRAM access enable.
- `data_sram_wen` output 4: byte write enables (0 for reads).
- `data_sram_addr` output ADDR_W: SRAM address.
- `data_sram_wdata` output 32: SRAM write data.
- `data_sram_rdata` input 32: SRAM read data, valid one cycle after `en`.

## Operation
- **Grant.** Decided combinationally each cycle from `p*_req`, the lock owner and the priority state.
  - If a lock owner exists, only that port may be granted. The other port's `addr_ok` stays 0.
  - Otherwise, if exactly one port requests, it is granted.
  - If both request, the port selected by the priority rule (see Configuration) is granted.
- **Accept.** An access is accepted when `pN_req && pN_addr_ok`.
  - In that cycle: `data_sram_en` = 1, addr/wdata muxed from port N.
  - `data_sram_wen` = `pN_wr ? pN_wstrb : 4'b0000`.
  - A write with `wstrb` = 0 is still accepted and still acknowledged.
- **No grant.** `data_sram_en` = 0, `data_sram_wen` = 0, addr/wdata = port 0 values.
- **Response register.** `resp_valid` and `resp_port` are loaded on every accept and cleared when no accept occurs.
  - The cycle after an accept: `p<resp_port>_data_ok` = 1 for both reads and writes.
  - `p<resp_port>_rdata` = `data_sram_rdata`. The other port's `rdata` is 0.
- **Lock ownership (`lock_valid`, `lock_port`).**
  - Set on accept when `pN_lock` = 1.
  - Cleared on an accept by the owner with `pN_lock` = 0.
  - Also cleared if the owner drops `pN_req` while `pN_lock` = 0.
  - While the owner keeps `lock` = 1 with no request, ownership holds and the SRAM idles.
- **Throughput.** Back-to-back accepts are allowed (one per cycle); the responses pipeline one cycle behind.

## Timing
- **Reset values** (`resetn` low, asynchronous):
  - `resp_valid` = 0, `lock_valid` = 0, priority pointer = port 0.
  - Both `data_ok` = 0, both `rdata` = 0.
  - `addr_ok` and the SRAM outputs follow the combinational rules with no lock.
- **Reset mid-operation:** any in-flight response is dropped; no `data_ok` is issued after reset release.
- **Latency:** `addr_ok` is in the same cycle as a qualifying `req`; `data_ok` follows exactly 1 cycle after the accept.
- **Same-cycle events:**
  - Accept in cycle T and accept in T+1 → `data_ok` at T+1 and T+2; no bubble.
  - A response to port X and a new grant to port Y in the same cycle are independent.
- **Stall:** `req` with `addr_ok` = 0 → the requester holds addr/wr/wstrb/wdata/lock stable. The arbiter keeps no copy of them.

## Configuration
- `DSRAM_ARB_RR_EN` defined:
  - Round-robin between the ports.
  - The priority pointer flips to the non-granted port after every accept in which both ports requested.
  - The pointer is unchanged otherwise.
- Undefined:
  - Fixed priority: port 0 always wins a tie.
  - Pointer logic is absent, so port 1 can starve.

## Test plan
- **Single read.** Reset, `p0` read at `0x100` (SRAM returns `0xDEADBEEF`) → `p0_addr_ok` at T, `data_sram_en` = 1 / `wen` = 0 at T, `p0_data_ok` = 1 with `p0_rdata` = `0xDEADBEEF` at T+1, `p1_data_ok` = 0.
- **Tie.** Both ports request every cycle for 4 cycles.
  - With `DSRAM_ARB_RR_EN`: grants 0,1,0,1.
  - Without it: grants 0,0,0,0.
  - `data_ok` routing matches each grant one cycle later.
- **Lock.** `p1` write `0x200` `wstrb` = `4'b0011` with lock = 1, then `p1` read `0x200` lock = 0, while `p0` requests throughout → `p0` blocked for both cycles, `data_sram_wen` = `0011` then `0000`, `p0` granted on the third cycle.
- **Back-to-back.** `p0` read, read, write at `0x0/0x4/0x8` on consecutive cycles → three consecutive `p0_data_ok` pulses at T+1..T+3, rdata matching the SRAM each cycle.
- **Reset mid-flight.** Accept a read at T, assert `resetn` = 0 during T+1 → `p0_data_ok` = 0 immediately; after release, no stray `data_ok` and lock cleared.
